seqdect_param: RTL

//  Parametrised serial pattern detector, next generation of the fixed 101010 detector.
//  - Samples one serial bit per enabled clock on prtx.
//  - Compares the last PAT_W bits against a runtime-loadable pattern with a don't-care mask.
//  - Selectable overlap / non-overlap search; registered one-cycle match pulse on prtz.
//  - Sits on serial receive paths as a frame/sync-word spotter.

---
 rtl/seqdect_pkg.sv | 22 ++
 rtl/seqdect_window.sv | 78 +++++++
 rtl/seqdect_param.sv | 112 +++++++++++
 3 files changed

// File: rtl/seqdect_pkg.sv
// -----------------------------------------------------------------------------
// seqdect_pkg
// Shared types and constants for the parametrised serial pattern detector.
//   fill_state_e : how much of the search window holds valid bits
//   DEF_PAT6     : default 6-bit sync word (LSB = newest serial bit)
//   fill_width() : width of the fill counter, which must be able to hold PAT_W
// -----------------------------------------------------------------------------
package seqdect_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,   // no valid bits in the window
        FILLING = 2'd1,   // some valid bits, not enough to complete a match
        ARMED   = 2'd2    // next enabled bit can complete a match
    } fill_state_e;

    localparam logic [5:0] DEF_PAT6 = 6'b101010;

    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdect_window.sv
// -----------------------------------------------------------------------------
// seqdect_window
// Serial shift window plus a saturating count of valid bits held in it.
// Ports:
//   clk    in  1      clock
//   rst    in  1      asynchronous active-high reset
//   shift  in  1      shift din into the window LSB
//   clear  in  1      restart the fill count (window contents kept)
//   din    in  1      serial bit
//   win    out PAT_W  window, bit 0 = newest bit
//   armed  out 1      at least PAT_W-1 valid bits held
// -----------------------------------------------------------------------------
module seqdect_window
    import seqdect_pkg::*;
#(
    parameter int PAT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             din,
    output logic [PAT_W-1:0] win,
    output logic             armed
);

    localparam int                FILL_W   = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] ARM_AT   = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  win_q, win_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    fill_state_e       state;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (shift) begin
            win_d = {win_q[PAT_W-2:0], din};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
        // Clear outranks the increment: after a non-overlapping hit or a
        // pattern load the search starts from scratch.
        if (clear) begin
            fill_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

    always_comb begin
        if (fill_q == '0) begin
            state = EMPTY;
        end else if (fill_q >= ARM_AT) begin
            state = ARMED;
        end else begin
            state = FILLING;
        end
    end

    assign win   = win_q;
    assign armed = (state == ARMED);

endmodule

// File: rtl/seqdect_param.sv
// -----------------------------------------------------------------------------
// seqdect_param
// Parametrised serial sync-word spotter. Compares the last PAT_W bits of the
// serial stream against a runtime-loadable pattern with a don't-care mask and
// emits a registered one-cycle match pulse.
// Optional feature: define MATCH_COUNT_EN to build the saturating match
// counter; otherwise match_cnt reads 0 and cnt_clr is ignored.
// Ports:
//   clk        in  1      clock
//   rst        in  1      asynchronous active-high reset
//   prtx       in  1      serial data bit
//   en         in  1      prtx valid this cycle
//   ovl        in  1      1 = overlapping matches, 0 = restart after a match
//   pat_load   in  1      load pat_in/mask_in (wins over en)
//   pat_in     in  PAT_W  new pattern, bit 0 = newest serial bit
//   mask_in    in  PAT_W  1 = compare bit, 0 = don't care
//   cnt_clr    in  1      synchronous clear of match_cnt
//   prtz       out 1      registered match pulse
//   match_cnt  out CNT_W  saturating match count
// -----------------------------------------------------------------------------
module seqdect_param
    import seqdect_pkg::*;
#(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT6),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prtx,
    input  logic             en,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             cnt_clr,
    output logic             prtz,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0] pat_q, mask_q;
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] cand;
    logic             armed;
    logic             hit;
    logic             prtz_q;
    logic             win_msb_unused;

    // A load discards any simultaneous serial bit and restarts the search.
    seqdect_window #(.PAT_W(PAT_W)) u_window (
        .clk   (clk),
        .rst   (rst),
        .shift (en & ~pat_load),
        .clear (pat_load | (hit & ~ovl)),
        .din   (prtx),
        .win   (win),
        .armed (armed)
    );

    // The oldest window bit falls off when the candidate is formed.
    assign win_msb_unused = win[PAT_W-1];

    // Candidate is the window as it will look once prtx is shifted in, so the
    // hit is known in the same cycle the completing bit arrives.
    assign cand = {win[PAT_W-2:0], prtx};
    assign hit  = en & armed & ~pat_load & (((cand ^ pat_q) & mask_q) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= DEF_PAT;
            mask_q <= '1;
            prtz_q <= 1'b0;
        end else begin
            if (pat_load) begin
                pat_q  <= pat_in;
                mask_q <= mask_in;
            end
            prtz_q <= hit;
        end
    end

    assign prtz = prtz_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic cnt_clr_unused;

    assign cnt_clr_unused = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule
